// File: rtl/spi_gray_pkg.sv
// Shared constants, receiver FSM states and the Gray-to-binary helper
// for the spi_gray_rx block.
package spi_gray_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_STATUS = 3'd2;
   localparam logic [2:0] ADDR_CTRL   = 3'd4;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_ABORT = 3;
   localparam int ST_LVL   = 4;

   localparam int CTRL_RX_EN  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_CLR    = 7;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_SHIFT,
      RX_HOLD
   } rx_state_t;

   // bin[i] is the XOR of all Gray bits from the MSB down to i
   function automatic logic [7:0] gray2bin(input logic [7:0] g, input int unsigned n);
      logic [7:0] m;
      logic [7:0] b;
      m = g & 8'((32'd1 << n) - 32'd1);
      b = '0;
      for (int i = 0; i < 8; i++) b[i] = ^(m >> i);
      return b;
   endfunction

endpackage

// File: rtl/spi_gray_rx_if.sv
// Bus bundle for spi_gray_rx: the SPI link from the Gray converter,
// the APB slave port and the interrupt line.
interface spi_gray_rx_if;
   logic       sclk;
   logic       cs;
   logic       mosi;
   logic [2:0] paddr;
   logic [7:0] pwdata;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic       pready;
   logic       pslverr;
   logic [7:0] prdata;
   logic       irq;

   modport master (
      output sclk, cs, mosi, paddr, pwdata, psel, penable, pwrite,
      input  pready, pslverr, prdata, irq
   );

   modport slave (
      input  sclk, cs, mosi, paddr, pwdata, psel, penable, pwrite,
      output pready, pslverr, prdata, irq
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [LW-1:0]    cnt;
   logic             do_push, do_pop;

   assign full    = (cnt == LW'(DEPTH));
   assign empty   = (cnt == '0);
   assign level   = cnt;
   assign dout    = mem[rptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
         if (do_pop)  rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/spi_gray_rx.sv
// SPI deframer + Gray decoder + FIFO with an APB register port.
// Define GRAY_DECODE_EN to decode words; otherwise raw frames are stored.
module spi_gray_rx
   import spi_gray_pkg::*;
#(
   parameter int NO_OF_SPI_BITS = 8,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic         clk,
   input  logic         rst,
   spi_gray_rx_if.slave bus
);

   localparam int N  = NO_OF_SPI_BITS;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic          sclk_q, cs_q;
   logic          strobe, cs_fall, cs_rise;
   rx_state_t     st, st_nxt;
   logic [3:0]    bitcnt;
   logic [N-1:0]  shreg;
   logic          shift, start, done, abort_set, word_vld;

   logic [N-1:0]  fifo_din, fifo_dout;
   logic          fifo_full, fifo_empty, fifo_pop;
   logic [LW-1:0] fifo_level;

   logic          rx_en, irq_en, ovf, abort;
   logic          setup, ctrl_wr, clr, ovf_set, apb_err;
   logic [7:0]    rd_val;
   logic [7:0]    prdata_r;
   logic          pready_r, pslverr_r, irq_r;
   logic          unused_pwdata;

   assign strobe  = sclk_q & ~bus.sclk & ~bus.cs & rx_en;
   assign cs_fall = cs_q & ~bus.cs;
   assign cs_rise = ~cs_q & bus.cs;

   always_comb begin
      st_nxt    = st;
      shift     = 1'b0;
      start     = 1'b0;
      done      = 1'b0;
      abort_set = 1'b0;
      if (cs_fall) begin
         st_nxt = RX_SHIFT;
         start  = 1'b1;
      end else begin
         case (st)
            RX_SHIFT: begin
               if (!rx_en) begin
                  st_nxt = RX_IDLE;
               end else if (cs_rise) begin
                  st_nxt    = RX_IDLE;
                  abort_set = (bitcnt != 4'd0);
               end else if (strobe) begin
                  shift = 1'b1;
                  if (bitcnt == 4'(N-1)) begin
                     done   = 1'b1;
                     st_nxt = RX_HOLD;
                  end
               end
            end
            RX_HOLD:  if (cs_rise) st_nxt = RX_IDLE;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q   <= 1'b0;
         cs_q     <= 1'b1;
         st       <= RX_IDLE;
         bitcnt   <= '0;
         shreg    <= '0;
         word_vld <= 1'b0;
      end else begin
         sclk_q   <= bus.sclk;
         cs_q     <= bus.cs;
         st       <= st_nxt;
         word_vld <= done;
         if (start) begin
            bitcnt <= '0;
            shreg  <= '0;
         end else if (shift) begin
            bitcnt <= bitcnt + 4'd1;
            shreg  <= {shreg[N-2:0], bus.mosi};
         end
      end
   end

   // The completed word sits stable in shreg while in RX_HOLD, so the push
   // one cycle later still sees it.
`ifdef GRAY_DECODE_EN
   assign fifo_din = N'(gray2bin(8'(shreg), N));
`else
   assign fifo_din = shreg;
`endif

   sync_fifo #(
      .WIDTH (N),
      .DEPTH (FIFO_DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (word_vld),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign setup    = bus.psel & ~bus.penable;
   assign fifo_pop = setup & ~bus.pwrite & (bus.paddr == ADDR_DATA) & ~fifo_empty;
   assign ctrl_wr  = setup & bus.pwrite & (bus.paddr == ADDR_CTRL);
   assign clr      = ctrl_wr & bus.pwdata[CTRL_CLR];
   assign ovf_set  = word_vld & fifo_full & ~fifo_pop;
   assign unused_pwdata = ^bus.pwdata[6:2];

   always_comb begin
      rd_val  = '0;
      apb_err = 1'b0;
      case (bus.paddr)
         ADDR_DATA: begin
            apb_err = bus.pwrite | fifo_empty;
            if (!fifo_empty) rd_val = 8'(fifo_dout);
         end
         ADDR_STATUS: begin
            apb_err              = bus.pwrite;
            rd_val[ST_EMPTY]     = fifo_empty;
            rd_val[ST_FULL]      = fifo_full;
            rd_val[ST_OVF]       = ovf;
            rd_val[ST_ABORT]     = abort;
            rd_val[ST_LVL +: 4]  = 4'(fifo_level);
         end
         ADDR_CTRL: begin
            rd_val[CTRL_RX_EN]  = rx_en;
            rd_val[CTRL_IRQ_EN] = irq_en;
         end
         default: apb_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prdata_r  <= '0;
         pready_r  <= 1'b0;
         pslverr_r <= 1'b0;
         rx_en     <= 1'b1;
         irq_en    <= 1'b0;
         ovf       <= 1'b0;
         abort     <= 1'b0;
         irq_r     <= 1'b0;
      end else begin
         pready_r  <= setup;
         pslverr_r <= setup & apb_err;
         if (setup && !bus.pwrite) prdata_r <= rd_val;
         if (ctrl_wr) begin
            rx_en  <= bus.pwdata[CTRL_RX_EN];
            irq_en <= bus.pwdata[CTRL_IRQ_EN];
         end
         // A new event in the same cycle as a clear keeps the flag set
         ovf   <= ovf_set   | (ovf   & ~clr);
         abort <= abort_set | (abort & ~clr);
         irq_r <= irq_en & (~fifo_empty | ovf | abort);
      end
   end

   assign bus.prdata  = prdata_r;
   assign bus.pready  = pready_r;
   assign bus.pslverr = pslverr_r;
   assign bus.irq     = irq_r;

endmodule

// File: tb/tb_spi_gray_rx.sv
// Directed bench for spi_gray_rx: framing, FIFO/ovf, abort, APB errors,
// irq timing, rx_en disable and async reset.
module tb_spi_gray_rx;
   import spi_gray_pkg::*;

`ifdef GRAY_DECODE_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   spi_gray_rx_if bus ();

   spi_gray_rx #(
      .NO_OF_SPI_BITS (8),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // expected word: decoded binary in the decode build, raw Gray otherwise
   function automatic logic [7:0] dec(input logic [7:0] g, input logic [7:0] b);
      return DEC ? b : g;
   endfunction

   task automatic frame(input logic [7:0] w, input int nbits, input bit raise);
      @(negedge clk) bus.cs = 1'b0;
      @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         bus.mosi = w[7-i];
         bus.sclk = 1'b1;
         @(negedge clk);
         bus.sclk = 1'b0;
      end
      if (raise) begin
         @(negedge clk) bus.cs = 1'b1;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic apb(input bit wr, input logic [2:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic rdy, output logic err);
      @(negedge clk);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = wr;
      bus.paddr   = a;
      bus.pwdata  = wd;
      @(negedge clk);
      rd  = bus.prdata;
      rdy = bus.pready;
      err = bus.pslverr;
      bus.penable = 1'b1;
      @(negedge clk);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp, input logic exp_err);
      logic [7:0] d;
      logic r, e;
      apb(1'b0, a, 8'h00, d, r, e);
      chk({tag, ".data"}, d, exp);
      chk({tag, ".err"}, {7'd0, e}, {7'd0, exp_err});
   endtask

   task automatic wr_chk(input string tag, input logic [2:0] a, input logic [7:0] wd, input logic exp_err);
      logic [7:0] d;
      logic r, e;
      apb(1'b1, a, wd, d, r, e);
      chk({tag, ".rdy"}, {7'd0, r}, 8'h01);
      chk({tag, ".err"}, {7'd0, e}, {7'd0, exp_err});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] g5 [5];
      logic [7:0] d;
      logic r, e;
      g5 = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};

      bus.sclk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0; bus.pwdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.prdata",  bus.prdata, 8'h00);
      chk("rst.pready",  {7'd0, bus.pready}, 8'h00);
      chk("rst.pslverr", {7'd0, bus.pslverr}, 8'h00);
      chk("rst.irq",     {7'd0, bus.irq}, 8'h00);
      rst = 1'b0;
      rd_chk("rst.status", ADDR_STATUS, 8'h01, 1'b0);
      rd_chk("rst.ctrl",   ADDR_CTRL,   8'h01, 1'b0);

      // single frame: Gray 0xF7 carries operand 0xA5
      frame(8'hF7, 8, 1'b1);
      rd_chk("t1.data",   ADDR_DATA,   dec(8'hF7, 8'hA5), 1'b0);
      rd_chk("t1.status", ADDR_STATUS, 8'h01, 1'b0);

      // five frames into a 4-deep FIFO: the fifth is dropped
      for (int i = 0; i < 5; i++) frame(g5[i], 8, 1'b1);
      rd_chk("t2.status_full", ADDR_STATUS, 8'h46, 1'b0);
      for (int i = 0; i < 4; i++)
         rd_chk($sformatf("t2.data%0d", i), ADDR_DATA, dec(g5[i], 8'(i + 1)), 1'b0);
      rd_chk("t2.status_drained", ADDR_STATUS, 8'h05, 1'b0);
      wr_chk("t2.clr", ADDR_CTRL, 8'h81, 1'b0);
      rd_chk("t2.status_clr", ADDR_STATUS, 8'h01, 1'b0);
      rd_chk("t2.ctrl",       ADDR_CTRL,   8'h01, 1'b0);

      // partial frame aborts, next full frame still lands
      frame(8'hFF, 3, 1'b1);
      rd_chk("t3.status_abort", ADDR_STATUS, 8'h09, 1'b0);
      frame(8'h00, 8, 1'b1);
      rd_chk("t3.status_rx", ADDR_STATUS, 8'h18, 1'b0);
      rd_chk("t3.data",      ADDR_DATA,   8'h00, 1'b0);
      wr_chk("t3.clr", ADDR_CTRL, 8'h81, 1'b0);
      rd_chk("t3.status_clr", ADDR_STATUS, 8'h01, 1'b0);

      // APB error cases
      apb(1'b0, ADDR_DATA, 8'h00, d, r, e);
      chk("t4.empty.data", d, 8'h00);
      chk("t4.empty.rdy",  {7'd0, r}, 8'h01);
      chk("t4.empty.err",  {7'd0, e}, 8'h01);
      chk("t4.rdy_pulse",  {7'd0, bus.pready}, 8'h00);
      chk("t4.err_pulse",  {7'd0, bus.pslverr}, 8'h00);
      rd_chk("t4.addr6", 3'd6, 8'h00, 1'b1);
      wr_chk("t4.wr_status", ADDR_STATUS, 8'h00, 1'b1);
      wr_chk("t4.wr_data",   ADDR_DATA,   8'h00, 1'b1);

      // clearing rx_en mid-frame drops the frame silently
      frame(8'hAA, 4, 1'b0);
      wr_chk("t5.dis", ADDR_CTRL, 8'h00, 1'b0);
      @(negedge clk) bus.cs = 1'b1;
      repeat (2) @(negedge clk);
      rd_chk("t5.status", ADDR_STATUS, 8'h01, 1'b0);
      rd_chk("t5.ctrl",   ADDR_CTRL,   8'h00, 1'b0);
      wr_chk("t5.en", ADDR_CTRL, 8'h01, 1'b0);

      // irq rises two edges after the last bit, drops after the pop
      wr_chk("t6.irq_en", ADDR_CTRL, 8'h03, 1'b0);
      chk("t6.irq_idle", {7'd0, bus.irq}, 8'h00);
      frame(8'h3C, 8, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("t6.irq_t1", {7'd0, bus.irq}, 8'h00);
      @(negedge clk);
      chk("t6.irq_t2", {7'd0, bus.irq}, 8'h01);
      bus.cs = 1'b1;
      rd_chk("t6.data", ADDR_DATA, dec(8'h3C, 8'h28), 1'b0);
      repeat (2) @(negedge clk);
      chk("t6.irq_clr", {7'd0, bus.irq}, 8'h00);

      // async reset mid-frame
      frame(8'hF7, 8, 1'b1);
      rd_chk("t7.status", ADDR_STATUS, 8'h10, 1'b0);
      chk("t7.irq_pre", {7'd0, bus.irq}, 8'h01);
      frame(8'h55, 3, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t7.prdata",  bus.prdata, 8'h00);
      chk("t7.pready",  {7'd0, bus.pready}, 8'h00);
      chk("t7.pslverr", {7'd0, bus.pslverr}, 8'h00);
      chk("t7.irq",     {7'd0, bus.irq}, 8'h00);
      bus.cs = 1'b1;
      @(negedge clk) rst = 1'b0;
      rd_chk("t7.status_post", ADDR_STATUS, 8'h01, 1'b0);
      rd_chk("t7.ctrl_post",   ADDR_CTRL,   8'h01, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
